led_mode_ctrl: RTL

- Control stage that sits directly upstream of the board LED pins and replaces the free-running blink counter.
- Takes a raw push-button input and debounces it. Each press cycles the LED pair through four modes: OFF, ON, BLINK and BREATHE.
- Drives led1/led2 as registered outputs. led2 is the complement of led1 in the animated modes, as on the current board.

---
 rtl/led_mode_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced push-button mode selector driving the board LED pair.
// Each accepted press steps OFF -> ON -> BLINK -> BREATHE -> OFF. A shared
// millisecond-style tick paces the debouncer, the blink half-period and the
// breathe ramp. led2 mirrors led1 in the static modes and is its complement
// in the animated ones.
module led_mode_ctrl #(
  parameter int CLK_FREQ       = 80000000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int BLINK_TICKS    = 500,
  parameter int PWM_BITS       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       led1,
  output logic       led2,
  output logic [1:0] mode
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Timebase
  logic [PRE_W-1:0]    r_pre_cnt;
  logic                w_tick;

  // Button path
  logic                r_sync1;
  logic                r_sync2;
  logic                w_btn_s;
  logic                r_stable;
  logic                r_stable_d;
  logic [DB_W-1:0]     r_db_cnt;
  logic                w_press;

  // Mode state
  mode_e               r_mode;
  mode_e               w_mode_next;
  logic                w_enter_blink;
  logic                w_enter_breathe;

  // Animation state
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_dir_up;

  // Output stage
  logic                w_led1_next;
  logic                w_led2_next;
  logic                r_led1;
  logic                r_led2;

  assign w_tick  = (r_pre_cnt == PRE_LAST);
  assign w_btn_s = r_sync2;
  // The accepted level rose on the previous edge: one pulse per press, none on release.
  assign w_press = r_stable & ~r_stable_d;

  // Prescaler: free-running 0..DIV-1, tick marks the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt <= {PRE_W{1'b0}};
    end else if (w_tick) begin
      r_pre_cnt <= {PRE_W{1'b0}};
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: a new level must persist for DEBOUNCE_TICKS ticks; any bounce back restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_db_cnt   <= {DB_W{1'b0}};
    end else begin
      r_stable_d <= r_stable;
      if (w_btn_s == r_stable) begin
        r_db_cnt <= {DB_W{1'b0}};
      end else if (w_tick) begin
        if (r_db_cnt == DB_LAST) begin
          r_stable <= w_btn_s;
          r_db_cnt <= {DB_W{1'b0}};
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Mode next-state: advance on press and flag the mode being entered.
  always_comb begin
    w_mode_next     = r_mode;
    w_enter_blink   = 1'b0;
    w_enter_breathe = 1'b0;
    if (w_press) begin
      case (r_mode)
        MODE_OFF: begin
          w_mode_next = MODE_ON;
        end
        MODE_ON: begin
          w_mode_next   = MODE_BLINK;
          w_enter_blink = 1'b1;
        end
        MODE_BLINK: begin
          w_mode_next     = MODE_BREATHE;
          w_enter_breathe = 1'b1;
        end
        MODE_BREATHE: begin
          w_mode_next = MODE_OFF;
        end
        default: begin
          w_mode_next = MODE_OFF;
        end
      endcase
    end else begin
      w_mode_next = r_mode;
    end
  end

  // Blink half-period counter; entry reinitialises and takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_cnt <= {BLK_W{1'b0}};
      r_phase   <= 1'b0;
    end else if (w_enter_blink) begin
      r_blk_cnt <= {BLK_W{1'b0}};
      r_phase   <= 1'b0;
    end else if (w_tick && (r_mode == MODE_BLINK)) begin
      if (r_blk_cnt == BLK_LAST) begin
        r_blk_cnt <= {BLK_W{1'b0}};
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end
  end

  // Free-running PWM counter shared by the breathe comparator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= DUTY_ZERO;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + DUTY_ONE;
    end
  end

  // Breathe triangle ramp: direction flips on arriving at either end, so duty never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty   <= DUTY_ZERO;
      r_dir_up <= 1'b1;
    end else if (w_enter_breathe) begin
      r_duty   <= DUTY_ZERO;
      r_dir_up <= 1'b1;
    end else if (w_tick && (r_mode == MODE_BREATHE)) begin
      if (r_dir_up) begin
        if (r_duty == DUTY_MAX) begin
          r_duty   <= r_duty - DUTY_ONE;
          r_dir_up <= 1'b0;
        end else begin
          r_duty <= r_duty + DUTY_ONE;
          if (r_duty == (DUTY_MAX - DUTY_ONE)) begin
            r_dir_up <= 1'b0;
          end
        end
      end else begin
        if (r_duty == DUTY_ZERO) begin
          r_duty   <= r_duty + DUTY_ONE;
          r_dir_up <= 1'b1;
        end else begin
          r_duty <= r_duty - DUTY_ONE;
          if (r_duty == DUTY_ONE) begin
            r_dir_up <= 1'b1;
          end
        end
      end
    end
  end

  // LED pattern selection for the current mode.
  always_comb begin
    w_led1_next = 1'b0;
    w_led2_next = 1'b0;
    case (r_mode)
      MODE_OFF: begin
        w_led1_next = 1'b0;
        w_led2_next = 1'b0;
      end
      MODE_ON: begin
        w_led1_next = 1'b1;
        w_led2_next = 1'b1;
      end
      MODE_BLINK: begin
        w_led1_next = ~r_phase;
        w_led2_next = r_phase;
      end
      MODE_BREATHE: begin
        w_led1_next = (r_pwm_cnt < r_duty);
        w_led2_next = ~(r_pwm_cnt < r_duty);
      end
      default: begin
        w_led1_next = 1'b0;
        w_led2_next = 1'b0;
      end
    endcase
  end

  // Registered LED drive so the pins never see combinational glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led1 <= 1'b0;
      r_led2 <= 1'b0;
    end else begin
      r_led1 <= w_led1_next;
      r_led2 <= w_led2_next;
    end
  end

  assign led1 = r_led1;
  assign led2 = r_led2;
  assign mode = r_mode;

endmodule
